// File: rtl/seg7_calc_scan_pkg.sv
// Shared types and constants for the scanned add/sub 7-segment calculator:
// segment codes, conversion FSM states and BCD sizing.
package seg7_calc_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;

    // Active-high abcdefg pattern for a decimal digit; non-decimal codes blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1111110;
            4'd1:    seg_code = 7'b0110000;
            4'd2:    seg_code = 7'b1101101;
            4'd3:    seg_code = 7'b1111001;
            4'd4:    seg_code = 7'b0110011;
            4'd5:    seg_code = 7'b1011011;
            4'd6:    seg_code = 7'b1011111;
            4'd7:    seg_code = 7'b1110000;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1111011;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Decimal digits needed for the largest (width+1)-bit magnitude.
    function automatic int bcd_digits(input int width);
        longint v;
        int     n;
        v = (longint'(1) << (width + 1)) - longint'(1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > longint'(0)) begin
                v = v / longint'(10);
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_calc_scan_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle for IN_W cycles, then a
// single LOAD cycle during which done is high and bcd holds the result.
module bin2bcd_seq
    import seg7_calc_scan_pkg::*;
#(
    parameter int IN_W = 9,
    parameter int ND   = 3
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic [IN_W-1:0]   bin,
    output logic              busy,
    output logic              done,
    output logic [4*ND-1:0]   bcd
);

    localparam int                CNT_W = $clog2(IN_W + 1);
    localparam int                SH_W  = 4 * ND + IN_W;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(IN_W - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [SH_W-1:0]  sh_r;
    logic [4*ND-1:0]  adj_s;

    assign bcd = sh_r[SH_W-1 -: 4*ND];

    // Add-3 correction of every BCD nibble that would overflow on the next shift.
    always_comb begin
        adj_s = sh_r[SH_W-1 -: 4*ND];
        for (int i = 0; i < ND; i++) begin
            if (adj_s[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = adj_s[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = adj_s[4*i +: 4];
            end
        end
    end

    // Conversion FSM with registered busy/done.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            sh_r    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_r    <= SH_W'(bin);
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    sh_r  <= {adj_s[4*ND-2:0], sh_r[IN_W-1:0], 1'b0};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST) begin
                        done    <= 1'b1;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_calc_scan.sv
// Add/subtract calculator feeding a time-multiplexed 7-segment display with
// leading-zero blanking, minus sign and overflow indication.
module seg7_calc_scan
    import seg7_calc_scan_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              mo,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              neg,
    output logic              overflow,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig
);

    localparam int                ND      = bcd_digits(WIDTH);
    localparam int                PAD_W   = 4 * ((ND > DIGITS) ? ND : DIGITS);
    localparam int                PRE_W   = $clog2(SCAN_DIV);
    localparam int                IDX_W   = $clog2(DIGITS);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);

    logic [WIDTH:0]              res_s;
    logic                        res_neg_s;
    logic                        accept_s;
    logic                        busy_s;
    logic                        bcd_done_s;
    logic [4*ND-1:0]             bcd_s;
    logic [PAD_W-1:0]            bcd_pad_s;
    int                          nd_s;
    logic                        ovf_s;
    logic [DIGITS-1:0][6:0]      fmt_s;
    logic [DIGITS-1:0][6:0]      disp_nxt_s;
    logic [PRE_W-1:0]            pre_nxt_s;
    logic [IDX_W-1:0]            idx_nxt_s;

    logic                        neg_pend_r;
    logic                        neg_r;
    logic                        ovf_r;
    logic                        done_r;
    logic [DIGITS-1:0][6:0]      disp_r;
    logic [PRE_W-1:0]            pre_r;
    logic [IDX_W-1:0]            idx_r;
    logic [DIGITS-1:0]           dig_r;
    logic [7:0]                  seg_r;

    function automatic logic [7:0] drive_seg(input logic [6:0] code);
        if (SEG_ACTIVE_LOW) begin
            drive_seg = ~{code, 1'b0};
        end else begin
            drive_seg = {code, 1'b0};
        end
    endfunction

    // Magnitude and sign of a+b or |a-b|.
    always_comb begin
        if (mo == 1'b0) begin
            res_s     = {1'b0, a} + {1'b0, b};
            res_neg_s = 1'b0;
        end else if (a >= b) begin
            res_s     = {1'b0, a} - {1'b0, b};
            res_neg_s = 1'b0;
        end else begin
            res_s     = {1'b0, b} - {1'b0, a};
            res_neg_s = 1'b1;
        end
    end

    // The converter samples bin on its own accept, so operands are frozen there.
    assign accept_s = start & ~busy_s;

    bin2bcd_seq #(
        .IN_W (WIDTH + 1),
        .ND   (ND)
    ) u_bin2bcd (
        .CLK   (CLK),
        .CLR   (CLR),
        .start (accept_s),
        .bin   (res_s),
        .busy  (busy_s),
        .done  (bcd_done_s),
        .bcd   (bcd_s)
    );

    // Right-aligned digits, minus left of the top digit, all-minus on overflow.
    always_comb begin
        bcd_pad_s = PAD_W'(bcd_s);
        nd_s      = 1;
        for (int i = 1; i < ND; i++) begin
            if (bcd_pad_s[4*i +: 4] != 4'd0) begin
                nd_s = i + 1;
            end else begin
                nd_s = nd_s;
            end
        end
        ovf_s = ((nd_s + int'(neg_pend_r)) > DIGITS);
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_s) begin
                fmt_s[i] = SEG_MINUS;
            end else if (i < nd_s) begin
                fmt_s[i] = seg_code(bcd_pad_s[4*i +: 4]);
            end else if (neg_pend_r && (i == nd_s)) begin
                fmt_s[i] = SEG_MINUS;
            end else begin
                fmt_s[i] = SEG_BLANK;
            end
        end
    end

    // Next scan position and display contents, so dig and seg move together.
    always_comb begin
        if (pre_r == PRE_MAX) begin
            pre_nxt_s = '0;
            idx_nxt_s = (idx_r == IDX_MAX) ? '0 : idx_r + IDX_W'(1);
        end else begin
            pre_nxt_s = pre_r + PRE_W'(1);
            idx_nxt_s = idx_r;
        end
        if (bcd_done_s) begin
            disp_nxt_s = fmt_s;
        end else begin
            disp_nxt_s = disp_r;
        end
    end

    // Display registers, status flags and scan outputs.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            neg_pend_r <= 1'b0;
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                disp_r[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
            end
            pre_r      <= '0;
            idx_r      <= '0;
            dig_r      <= {{(DIGITS-1){1'b0}}, 1'b1};
            seg_r      <= drive_seg(SEG_ZERO);
        end else begin
            if (accept_s) begin
                neg_pend_r <= res_neg_s;
            end
            if (bcd_done_s) begin
                neg_r <= neg_pend_r;
                ovf_r <= ovf_s;
            end
            done_r <= bcd_done_s;
            disp_r <= disp_nxt_s;
            pre_r  <= pre_nxt_s;
            idx_r  <= idx_nxt_s;
            dig_r  <= {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt_s;
            seg_r  <= drive_seg(disp_nxt_s[idx_nxt_s]);
        end
    end

    assign busy     = busy_s;
    assign done     = done_r;
    assign neg      = neg_r;
    assign overflow = ovf_r;
    assign seg      = seg_r;
    assign dig      = dig_r;

endmodule

// File: tb/tb_seg7_calc_scan.sv
// Randomized self-checking bench: a 4-digit and a 3-digit instance share the
// same stimulus and are compared against a decimal-string display model.
module tb_seg7_calc_scan;

    localparam int W = 8;

    logic       CLK;
    logic       CLR;
    logic [7:0] a;
    logic [7:0] b;
    logic       mo;
    logic       start;

    logic       busy_a, done_a, neg_a, ovf_a;
    logic [7:0] seg_a;
    logic [3:0] dig_a;
    logic       busy_b, done_b, neg_b, ovf_b;
    logic [7:0] seg_b;
    logic [2:0] dig_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    seg7_calc_scan #(.WIDTH(W), .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .CLK(CLK), .CLR(CLR), .a(a), .b(b), .mo(mo), .start(start),
        .busy(busy_a), .done(done_a), .neg(neg_a), .overflow(ovf_a),
        .seg(seg_a), .dig(dig_a)
    );

    seg7_calc_scan #(.WIDTH(W), .DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .CLK(CLK), .CLR(CLR), .a(a), .b(b), .mo(mo), .start(start),
        .busy(busy_b), .done(done_b), .neg(neg_b), .overflow(ovf_b),
        .seg(seg_b), .dig(dig_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Text the display should show, before fitting it into nd positions.
    function automatic string disp_text(input int r, input bit ng);
        string s;
        s = $sformatf("%0d", r);
        if (ng) s = {"-", s};
        return s;
    endfunction

    function automatic logic [6:0] exp_code(input int r, input bit ng, input int nd, input int pos);
        string s;
        byte   ch;
        s = disp_text(r, ng);
        if (s.len() > nd) return 7'b0000001;
        if (pos >= s.len()) return 7'b0000000;
        ch = s[s.len() - 1 - pos];
        if (ch == "-") return 7'b0000001;
        return seg_tab[int'(ch) - 48];
    endfunction

    function automatic logic [3:0] rot4(input logic [3:0] d);
        return {d[2:0], d[3]};
    endfunction

    function automatic logic [2:0] rot3(input logic [2:0] d);
        return {d[1:0], d[2]};
    endfunction

    task automatic check_display(input int r, input bit ng, input string tag);
        int         bad_a = 0;
        int         bad_b = 0;
        logic [3:0] seen_a = 4'b0000;
        logic [2:0] seen_b = 3'b000;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if ($countones(dig_a) != 1) bad_a++;
            if ($countones(dig_b) != 1) bad_b++;
            for (int i = 0; i < 4; i++) begin
                if (dig_a == 4'(1 << i)) begin
                    seen_a[i] = 1'b1;
                    if (seg_a !== {exp_code(r, ng, 4, i), 1'b0}) bad_a++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (dig_b == 3'(1 << i)) begin
                    seen_b[i] = 1'b1;
                    if (seg_b !== {exp_code(r, ng, 3, i), 1'b0}) bad_b++;
                end
            end
        end
        chk({tag, " seg4 bad cycles"}, bad_a, 0);
        chk({tag, " seg3 bad cycles"}, bad_b, 0);
        chk({tag, " digits seen4"}, 32'(seen_a), 32'hF);
        chk({tag, " digits seen3"}, 32'(seen_b), 32'h7);
    endtask

    task automatic check_scan();
        logic [3:0] pa;
        logic [2:0] pb;
        int ra = 1, rb = 1, bad = 0, steps_a = 0, steps_b = 0;
        @(negedge CLK);
        pa = dig_a;
        pb = dig_b;
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            if (dig_a == pa) ra++;
            else begin
                if (steps_a > 0 && ra != 4) bad++;
                if (dig_a != rot4(pa)) bad++;
                steps_a++; ra = 1; pa = dig_a;
            end
            if (dig_b == pb) rb++;
            else begin
                if (steps_b > 0 && rb != 4) bad++;
                if (dig_b != rot3(pb)) bad++;
                steps_b++; rb = 1; pb = dig_b;
            end
        end
        chk("scan hold/order", bad, 0);
        chk("scan steps4", steps_a, 8);
        chk("scan steps3", steps_b, 8);
    endtask

    task automatic run_calc(input logic [7:0] ai, input logic [7:0] bi, input logic mi,
                            input bit restart, input bit abort, input string tag);
        int r, busy_cnt, dones_a, dones_b, done_at;
        bit ng, eo_a, eo_b;
        busy_cnt = 0; dones_a = 0; dones_b = 0; done_at = -1;
        if (!mi) begin r = int'(ai) + int'(bi); ng = 1'b0; end
        else if (ai >= bi) begin r = int'(ai) - int'(bi); ng = 1'b0; end
        else begin r = int'(bi) - int'(ai); ng = 1'b1; end
        @(negedge CLK);
        a = ai; b = bi; mo = mi; start = 1'b1;
        for (int n = 1; n <= W + 12; n++) begin
            @(negedge CLK);
            if (busy_a) busy_cnt++;
            if (busy_b != busy_a) busy_cnt += 100;
            if (done_a) begin dones_a++; done_at = n; end
            if (done_b) dones_b++;
            if (n == 1) begin
                start = 1'b0;
                a = 8'($urandom); b = 8'($urandom); mo = 1'($urandom);
            end
            if (restart && n == 3) begin
                start = 1'b1; a = 8'($urandom); b = 8'($urandom); mo = 1'($urandom);
            end
            if (restart && n == 4) start = 1'b0;
            if (abort && n == 5) begin #2 CLR = 1'b0; end
            if (abort && n == 6) CLR = 1'b1;
        end
        if (abort) begin
            r = 0; ng = 1'b0;
            chk({tag, " busy cycles"}, busy_cnt, 5);
            chk({tag, " done count"}, dones_a + dones_b, 0);
        end else begin
            chk({tag, " busy cycles"}, busy_cnt, W + 2);
            chk({tag, " done cycle"}, done_at, W + 3);
            chk({tag, " done count4"}, dones_a, 1);
            chk({tag, " done count3"}, dones_b, 1);
        end
        eo_a = (disp_text(r, ng).len() > 4);
        eo_b = (disp_text(r, ng).len() > 3);
        chk({tag, " neg4"}, 32'(neg_a), 32'(ng));
        chk({tag, " neg3"}, 32'(neg_b), 32'(ng));
        chk({tag, " ovf4"}, 32'(ovf_a), 32'(eo_a));
        chk({tag, " ovf3"}, 32'(ovf_b), 32'(eo_b));
        check_display(r, ng, tag);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rm;
        CLR = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; mo = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        repeat (6) @(negedge CLK);
        #2 CLR = 1'b0;
        #1;
        chk("reset dig4", 32'(dig_a), 32'h1);
        chk("reset seg4", 32'(seg_a), 32'hFC);
        chk("reset dig3", 32'(dig_b), 32'h1);
        chk("reset seg3", 32'(seg_b), 32'hFC);
        chk("reset busy", 32'({busy_a, busy_b}), 32'h0);
        chk("reset done", 32'({done_a, done_b}), 32'h0);
        chk("reset neg/ovf", 32'({neg_a, ovf_a, neg_b, ovf_b}), 32'h0);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (3) @(negedge CLK);
        chk("release dig hold", 32'(dig_a), 32'h1);
        @(negedge CLK);
        chk("release dig step", 32'(dig_a), 32'h2);
        check_display(0, 1'b0, "reset display");
        check_scan();

        run_calc(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, "add 300");
        run_calc(8'd5,   8'd12,  1'b1, 1'b0, 1'b0, "sub -7");
        run_calc(8'd0,   8'd255, 1'b1, 1'b0, 1'b0, "sub -255");
        run_calc(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, "add 510");
        run_calc(8'd0,   8'd0,   1'b0, 1'b0, 1'b0, "add zero");
        run_calc(8'd9,   8'd9,   1'b1, 1'b0, 1'b0, "sub equal");
        run_calc(8'd0,   8'd1,   1'b1, 1'b0, 1'b0, "sub -1");
        run_calc(8'd1,   8'd100, 1'b1, 1'b0, 1'b0, "sub -99");
        run_calc(8'd37,  8'd99,  1'b1, 1'b1, 1'b0, "restart ignored");
        run_calc(8'd123, 8'd45,  1'b0, 1'b0, 1'b1, "abort");
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 6 == 0) ? ra : 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            run_calc(ra, rb, rm, (k % 5 == 2), 1'b0, $sformatf("rand%0d", k));
        end
        check_scan();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
